// File: rtl/ld_st_pkg.sv
// rtl/ld_st_pkg.sv - opcodes, FSM encoding and opcode helpers for the load/store register controller
package ld_st_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SET  = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_READ = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_READ);
    endfunction

    function automatic logic op_modifies(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_SET) || (op == OP_CLR);
    endfunction

endpackage

// File: rtl/ld_st_bit_cell.sv
// rtl/ld_st_bit_cell.sv - one load/store storage cell: clear beats set beats load, else hold
module ld_st_bit_cell (
    input  logic clk,
    input  logic clr_n,
    input  logic set_n,
    input  logic ld_st,
    input  logic din,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q <= 1'b0;
        end else if (!set_n) begin
            q <= 1'b1;
        end else if (ld_st) begin
            q <= din;
        end
    end

endmodule

// File: rtl/ld_st_reg_ctrl.sv
// rtl/ld_st_reg_ctrl.sv - command/response controller driving a register of ld_st_bit_cell slices
// Optional stored-parity check on READ when LD_ST_PARITY_EN is defined.
module ld_st_reg_ctrl
    import ld_st_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [WIDTH-1:0] reg_q
);

    state_t           state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] data_r;
    logic             err_next;

    logic             in_exec;
    logic [WIDTH-1:0] cell_clr_n;
    logic [WIDTH-1:0] cell_set_n;
    logic [WIDTH-1:0] cell_ld;

    assign in_exec = (state == EXEC);

    // Global reset rides on every cell's clr_n so the cells need no reset of their own.
    assign cell_clr_n = {WIDTH{clr}} & ~({WIDTH{in_exec && (op_r == OP_CLR)}} & mask_r);
    assign cell_set_n = ~({WIDTH{in_exec && (op_r == OP_SET)}} & mask_r);
    assign cell_ld    = {WIDTH{in_exec && (op_r == OP_LOAD)}} & mask_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ld_st_bit_cell u_cell (
            .clk   (clk),
            .clr_n (cell_clr_n[i]),
            .set_n (cell_set_n[i]),
            .ld_st (cell_ld[i]),
            .din   (data_r[i]),
            .q     (reg_q[i])
        );
    end

`ifdef LD_ST_PARITY_EN
    logic [WIDTH-1:0] next_q;
    logic             par_q;

    always_comb begin
        next_q = reg_q;
        case (op_r)
            OP_LOAD: next_q = (reg_q & ~mask_r) | (data_r & mask_r);
            OP_SET:  next_q = reg_q | mask_r;
            OP_CLR:  next_q = reg_q & ~mask_r;
            default: next_q = reg_q;
        endcase
    end

    ld_st_bit_cell u_par_cell (
        .clk   (clk),
        .clr_n (clr),
        .set_n (1'b1),
        .ld_st (in_exec && op_modifies(op_r)),
        .din   (^next_q),
        .q     (par_q)
    );

    assign err_next = !op_is_legal(op_r) || ((op_r == OP_READ) && ((^reg_q) != par_q));
`else
    assign err_next = !op_is_legal(op_r);
`endif

    assign cmd_ready = clr && (state == IDLE);
    // reg_q only moves in EXEC, so it is already stable for the whole RESP window.
    assign rsp_data  = rsp_valid ? reg_q : '0;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= IDLE;
            op_r      <= OP_NOP;
            mask_r    <= '0;
            data_r    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r   <= cmd_op;
                        mask_r <= cmd_mask;
                        data_r <= cmd_data;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_next;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
